// File: rtl/fp_adder_pipe.sv
// Three-stage pipelined IEEE-754 binary adder/subtractor with subnormals,
// round-to-nearest-even, exception flags and valid/ready streaming.
module fp_adder_pipe #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     op,
  input  logic [EXP_W+MAN_W:0]     a,
  input  logic [EXP_W+MAN_W:0]     b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     result,
  output logic                     flag_invalid,
  output logic                     flag_overflow,
  output logic                     flag_underflow,
  output logic                     flag_inexact
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int GW = MAN_W + 4;  // hidden bit + fraction + guard/round/sticky
  localparam int EW = EXP_W + 2;

  typedef logic signed [EW-1:0] exp_t;

  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [EXP_W-1:0] EXP_ONE  = EXP_W'(1);
  localparam exp_t             E_ONE    = exp_t'(1);
  localparam exp_t             E_MAX    = exp_t'((1 << EXP_W) - 1);
  localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // ---------------- S1: unpack, classify, swap ----------------
  logic [EXP_W-1:0] a_exp, b_exp, l_exp, s_exp, l_eff, s_eff, diff;
  logic [MAN_W-1:0] a_frac, b_frac, l_frac, s_frac;
  logic             b_sign, l_sign, s_sign, swap;
  logic             a_nan, b_nan, a_inf, b_inf, is_special, spec_inv;
  logic [W-1:0]     spec_word;

  // NOTE: always_comb uses blocking assignments and gives every output a default first, so no latch can be inferred.
  always_comb begin
    a_exp  = a[W-2:MAN_W];
    b_exp  = b[W-2:MAN_W];
    a_frac = a[MAN_W-1:0];
    b_frac = b[MAN_W-1:0];
    b_sign = b[W-1] ^ op;
    a_nan  = (a_exp == EXP_ONES) && (a_frac != '0);
    b_nan  = (b_exp == EXP_ONES) && (b_frac != '0);
    a_inf  = (a_exp == EXP_ONES) && (a_frac == '0);
    b_inf  = (b_exp == EXP_ONES) && (b_frac == '0);

    // Raw magnitude bits order the same way as the values they encode.
    swap   = b[W-2:0] > a[W-2:0];
    l_sign = swap ? b_sign : a[W-1];
    s_sign = swap ? a[W-1] : b_sign;
    l_exp  = swap ? b_exp  : a_exp;
    s_exp  = swap ? a_exp  : b_exp;
    l_frac = swap ? b_frac : a_frac;
    s_frac = swap ? a_frac : b_frac;
    l_eff  = (l_exp == '0) ? EXP_ONE : l_exp;
    s_eff  = (s_exp == '0) ? EXP_ONE : s_exp;
    diff   = l_eff - s_eff;

    is_special = a_nan || b_nan || a_inf || b_inf;
    spec_inv   = 1'b0;
    spec_word  = QNAN;
    if (a_nan || b_nan) begin
      spec_word = QNAN;
    end else if (a_inf && b_inf && (a[W-1] != b_sign)) begin
      spec_inv = 1'b1;
    end else if (a_inf) begin
      spec_word = {a[W-1], EXP_ONES, {MAN_W{1'b0}}};
    end else if (b_inf) begin
      spec_word = {b_sign, EXP_ONES, {MAN_W{1'b0}}};
    end
  end

  logic             s1_valid, s1_special, s1_spec_inv, s1_sign, s1_eff_sub;
  logic [W-1:0]     s1_spec_word;
  exp_t             s1_exp;
  logic [MAN_W:0]   s1_man_l, s1_man_s;
  logic [EXP_W-1:0] s1_diff;

  // ---------------- S2: align and add/subtract ----------------
  logic [EXP_W-1:0] shamt;
  logic [2*GW-1:0]  shifted;
  logic [GW-1:0]    aligned;
  logic [GW:0]      sum;

  always_comb begin
    shamt   = (int'(s1_diff) > MAN_W + 3) ? EXP_W'(MAN_W + 3) : s1_diff;
    shifted = {s1_man_s, 3'b000, {GW{1'b0}}} >> shamt;
    aligned = shifted[2*GW-1:GW] | {{(GW-1){1'b0}}, |shifted[GW-1:0]};
    if (s1_eff_sub) sum = {1'b0, s1_man_l, 3'b000} - {1'b0, aligned};
    else            sum = {1'b0, s1_man_l, 3'b000} + {1'b0, aligned};
  end

  logic         s2_valid, s2_special, s2_spec_inv, s2_sign, s2_eff_sub;
  logic [W-1:0] s2_spec_word;
  exp_t         s2_exp;
  logic [GW:0]  s2_sum;

  // ---------------- S3: normalise, round, pack ----------------
  function automatic exp_t lzc(input logic [GW-1:0] v);
    lzc = exp_t'(GW);
    for (int i = 0; i < GW; i++)
      if (v[i]) lzc = exp_t'(GW - 1 - i);
  endfunction

  exp_t             lz, sh, exp_n, exp_f;
  logic [GW-1:0]    norm;
  logic [MAN_W:0]   mant_q, mant_f;
  logic [MAN_W+1:0] mant_r;
  logic             g_bit, r_bit, s_bit, rnd_up, inexact, overflow, res_sign;
  logic [EXP_W-1:0] exp_field;
  logic [W-1:0]     res_d;
  logic             inv_d, ovf_d, unf_d, inx_d;

  always_comb begin
    lz    = lzc(s2_sum[GW-1:0]);
    sh    = '0;
    norm  = '0;
    exp_n = s2_exp;
    if (s2_sum[GW]) begin
      norm  = {s2_sum[GW:2], |s2_sum[1:0]};
      exp_n = s2_exp + E_ONE;
    end else begin
      // Stop shifting at the minimum exponent; what remains is subnormal.
      sh    = (lz < s2_exp) ? lz : s2_exp - E_ONE;
      norm  = s2_sum[GW-1:0] << sh;
      exp_n = s2_exp - sh;
    end

    mant_q = norm[GW-1:3];
    g_bit  = norm[2];
    r_bit  = norm[1];
    s_bit  = norm[0];
    rnd_up = g_bit && (r_bit || s_bit || mant_q[0]);
    mant_r = {1'b0, mant_q} + {{(MAN_W+1){1'b0}}, rnd_up};
    if (mant_r[MAN_W+1]) begin
      mant_f = mant_r[MAN_W+1:1];
      exp_f  = exp_n + E_ONE;
    end else begin
      mant_f = mant_r[MAN_W:0];
      exp_f  = exp_n;
    end

    inexact   = g_bit || r_bit || s_bit;
    // A clear hidden bit after rounding means exponent 1 encoded as 0.
    exp_field = mant_f[MAN_W] ? exp_f[EXP_W-1:0] : '0;
    overflow  = mant_f[MAN_W] && (exp_f >= E_MAX);
    res_sign  = (s2_sum == '0) ? (s2_sign && !s2_eff_sub) : s2_sign;

    res_d = overflow ? {res_sign, EXP_ONES, {MAN_W{1'b0}}}
                     : {res_sign, exp_field, mant_f[MAN_W-1:0]};
    inv_d = 1'b0;
    ovf_d = overflow;
    unf_d = inexact && !overflow && !mant_f[MAN_W];
    inx_d = inexact || overflow;
    if (s2_special) begin
      res_d = s2_spec_word;
      inv_d = s2_spec_inv;
      ovf_d = 1'b0;
      unf_d = 1'b0;
      inx_d = 1'b0;
    end
  end

  // ---------------- registers ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid       <= 1'b0;
      s2_valid       <= 1'b0;
      out_valid      <= 1'b0;
      result         <= '0;
      flag_invalid   <= 1'b0;
      flag_overflow  <= 1'b0;
      flag_underflow <= 1'b0;
      flag_inexact   <= 1'b0;
    end else if (en) begin
      s1_valid  <= in_valid;
      s2_valid  <= s1_valid;
      out_valid <= s2_valid;
      if (s2_valid) begin
        result         <= res_d;
        flag_invalid   <= inv_d;
        flag_overflow  <= ovf_d;
        flag_underflow <= unf_d;
        flag_inexact   <= inx_d;
      end
    end
  end

  // NOTE: payload registers carry no reset; the valid bits alone decide whether their contents mean anything.
  always_ff @(posedge clk) begin
    if (en) begin
      s1_special   <= is_special;
      s1_spec_inv  <= spec_inv;
      s1_spec_word <= spec_word;
      s1_sign      <= l_sign;
      s1_eff_sub   <= l_sign ^ s_sign;
      s1_exp       <= {2'b00, l_eff};
      s1_man_l     <= {l_exp != '0, l_frac};
      s1_man_s     <= {s_exp != '0, s_frac};
      s1_diff      <= diff;

      s2_special   <= s1_special;
      s2_spec_inv  <= s1_spec_inv;
      s2_spec_word <= s1_spec_word;
      s2_sign      <= s1_sign;
      s2_eff_sub   <= s1_eff_sub;
      s2_exp       <= s1_exp;
      s2_sum       <= sum;
    end
  end

endmodule

// File: tb/tb_fp_adder_pipe.sv
// Self-checking bench for fp_adder_pipe (FP16 defaults): directed vectors,
// latency/backpressure/reset sequences and a randomized scoreboard run.
module tb_fp_adder_pipe;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, op, out_valid, out_ready;
  logic [15:0] a, b, result;
  logic        flag_invalid, flag_overflow, flag_underflow, flag_inexact;
  logic [3:0]  dut_flags;

  assign dut_flags = {flag_invalid, flag_overflow, flag_underflow, flag_inexact};

  always #5 clk = ~clk;

  fp_adder_pipe #(.EXP_W(5), .MAN_W(10)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flag_invalid(flag_invalid), .flag_overflow(flag_overflow),
    .flag_underflow(flag_underflow), .flag_inexact(flag_inexact)
  );

  int checks = 0;
  int errors = 0;
  int step_no = 0;

  // flags packed as {invalid, overflow, underflow, inexact}
  typedef struct packed { logic [15:0] res; logic [3:0] flg; } out_t;
  typedef struct { logic op; logic [15:0] a, b, res; logic [3:0] flg; } vec_t;

  out_t sb[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s (step %0d): got %h expected %h", name, step_no, got, exp);
    end
  endtask

  // Reference: exact sum as an integer count of 2^-24 units, then RNE to FP16.
  function automatic out_t model(input logic [15:0] x, input logic [15:0] y, input logic o);
    out_t   r;
    logic   sx, sy, sg, inx;
    int     ex, ey, fx, fy, k, e;
    longint vx, vy, s, m, q, rem, half;
    r  = '0;
    sx = x[15];
    sy = y[15] ^ o;
    ex = int'(x[14:10]);  fx = int'(x[9:0]);
    ey = int'(y[14:10]);  fy = int'(y[9:0]);
    if ((ex == 31 && fx != 0) || (ey == 31 && fy != 0)) begin
      r.res = 16'h7E00;
      return r;
    end
    if (ex == 31 && ey == 31 && sx != sy) begin
      r.res = 16'h7E00;
      r.flg = 4'b1000;
      return r;
    end
    if (ex == 31) begin r.res = {sx, 15'h7C00}; return r; end
    if (ey == 31) begin r.res = {sy, 15'h7C00}; return r; end
    vx = (ex == 0) ? longint'(fx) : longint'(fx + 1024) << (ex - 1);
    vy = (ey == 0) ? longint'(fy) : longint'(fy + 1024) << (ey - 1);
    s  = (sx ? -vx : vx) + (sy ? -vy : vy);
    if (s == 0) begin
      r.res = {sx & sy, 15'h0000};
      return r;
    end
    sg = (s < 0);
    m  = sg ? -s : s;
    k  = 0;
    while ((m >> k) >= 2048) k++;
    q   = m >> k;
    rem = m - (q << k);
    if (k > 0) begin
      half = longint'(1) << (k - 1);
      if (rem > half || (rem == half && q[0])) q++;
    end
    if (q == 2048) begin q = 1024; k++; end
    inx = (rem != 0);
    e   = (q < 1024) ? 0 : k + 1;
    if (e >= 31) begin
      r.res = {sg, 15'h7C00};
      r.flg = 4'b0101;
    end else begin
      r.res = {sg, 5'(e), 10'(q)};
      r.flg = {2'b00, inx && e == 0, inx};
    end
    return r;
  endfunction

  // One clock: drive at negedge, sample handshakes 1ns later (stable until posedge).
  task automatic step(input logic v, input logic o, input logic [15:0] ia, input logic [15:0] ib,
                      input logic ordy, input out_t e, output logic acc, output logic got);
    out_t x;
    @(negedge clk);
    in_valid  = v;
    op        = o;
    a         = ia;
    b         = ib;
    out_ready = ordy;
    #1;
    step_no++;
    acc = in_valid && in_ready;
    got = out_valid && out_ready;
    if (acc) sb.push_back(e);
    if (got) begin
      check("scoreboard_nonempty", 32'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        x = sb.pop_front();
        check("result", 32'(result), 32'(x.res));
        check("flags", 32'(dut_flags), 32'(x.flg));
      end
    end
  endtask

  task automatic idle(input logic ordy, output logic acc, output logic got);
    step(1'b0, 1'b0, 16'h0, 16'h0, ordy, '0, acc, got);
  endtask

  task automatic drain();
    logic acc, got;
    for (int i = 0; i < 20 && sb.size() > 0; i++) idle(1'b1, acc, got);
    check("drain_empty", 32'(sb.size()), 0);
    sb.delete();
  endtask

  function automatic logic [15:0] rand_op();
    logic [15:0] v;
    case ($urandom_range(0, 7))
      0: v = 16'($urandom);
      1: v = {1'($urandom), 5'h1F, ($urandom_range(0, 1) == 0) ? 10'h0 : 10'($urandom)};
      2: v = {1'($urandom), 5'h00, 10'($urandom)};
      default: v = {1'($urandom), 5'($urandom_range(1, 30)), 10'($urandom)};
    endcase
    return v;
  endfunction

  function automatic logic [15:0] rand_normal();
    return {1'($urandom), 5'($urandom_range(1, 30)), 10'($urandom)};
  endfunction

  vec_t        vecs[16];
  logic        acc, got;
  int          acc_step, seen, n_acc, n_got, first_got, last_got;
  logic [15:0] pa[5], pb[5], xa, xb;
  logic        xo;

  initial begin
    vecs[0]  = '{1'b0, 16'h3C00, 16'h3C00, 16'h4000, 4'b0000};
    vecs[1]  = '{1'b0, 16'h3C00, 16'h0C00, 16'h3C00, 4'b0001};
    vecs[2]  = '{1'b0, 16'h3C00, 16'h1000, 16'h3C00, 4'b0001};
    vecs[3]  = '{1'b0, 16'h3C01, 16'h1000, 16'h3C02, 4'b0001};
    vecs[4]  = '{1'b0, 16'h7BFF, 16'h7BFF, 16'h7C00, 4'b0101};
    vecs[5]  = '{1'b0, 16'h7C00, 16'hFC00, 16'h7E00, 4'b1000};
    vecs[6]  = '{1'b0, 16'h7E01, 16'h3C00, 16'h7E00, 4'b0000};
    vecs[7]  = '{1'b0, 16'h7C00, 16'h3C00, 16'h7C00, 4'b0000};
    vecs[8]  = '{1'b1, 16'h3C00, 16'h3C00, 16'h0000, 4'b0000};
    vecs[9]  = '{1'b0, 16'h8000, 16'h8000, 16'h8000, 4'b0000};
    vecs[10] = '{1'b0, 16'h0001, 16'h0001, 16'h0002, 4'b0000};
    vecs[11] = '{1'b1, 16'h0400, 16'h0001, 16'h03FF, 4'b0000};
    vecs[12] = '{1'b0, 16'h03FF, 16'h0001, 16'h0400, 4'b0000};
    vecs[13] = '{1'b0, 16'h0000, 16'h8000, 16'h0000, 4'b0000};
    vecs[14] = '{1'b1, 16'h7C00, 16'h7C00, 16'h7E00, 4'b1000};
    vecs[15] = '{1'b0, 16'hFBFF, 16'hFBFF, 16'hFC00, 4'b0101};

    rst_n = 1'b0; in_valid = 1'b0; op = 1'b0; a = '0; b = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", 32'(out_valid), 0);
    check("reset_result", 32'(result), 0);
    check("reset_flags", 32'(dut_flags), 0);
    rst_n = 1'b1;
    idle(1'b1, acc, got);
    check("reset_in_ready", 32'(in_ready), 1);

    // Latency of a single operation
    step(1'b1, 1'b0, 16'h3C00, 16'h3C00, 1'b1, '{16'h4000, 4'b0000}, acc, got);
    check("lat_accept", 32'(acc), 1);
    acc_step = step_no;
    seen = -1;
    for (int i = 0; i < 10 && seen < 0; i++) begin
      idle(1'b1, acc, got);
      if (got) seen = step_no;
    end
    check("latency", 32'(seen - acc_step), 3);
    drain();

    // Directed table
    foreach (vecs[i]) begin
      step(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, 1'b1, '{vecs[i].res, vecs[i].flg}, acc, got);
      check($sformatf("vec%0d_accept", i), 32'(acc), 1);
      drain();
    end

    // Back-to-back stream of 8
    n_acc = 0; n_got = 0; first_got = -1; last_got = -1;
    for (int i = 0; i < 20; i++) begin
      xa = rand_normal(); xb = rand_normal(); xo = 1'($urandom);
      if (i < 8) step(1'b1, xo, xa, xb, 1'b1, model(xa, xb, xo), acc, got);
      else       idle(1'b1, acc, got);
      if (acc) n_acc++;
      if (got) begin
        n_got++;
        if (first_got < 0) first_got = step_no;
        last_got = step_no;
      end
    end
    check("b2b_accepted", 32'(n_acc), 8);
    check("b2b_delivered", 32'(n_got), 8);
    check("b2b_consecutive", 32'(last_got - first_got), 7);
    drain();

    // Backpressure: 5 pairs offered with out_ready low
    for (int i = 0; i < 5; i++) begin pa[i] = rand_normal(); pb[i] = rand_normal(); end
    n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, pa[n_acc], pb[n_acc], 1'b0, model(pa[n_acc], pb[n_acc], 1'b0), acc, got);
      if (acc) n_acc++;
    end
    check("bp_accepted", 32'(n_acc), 3);
    check("bp_in_ready", 32'(in_ready), 0);
    check("bp_out_valid", 32'(out_valid), 1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, pa[n_acc], pb[n_acc], 1'b0, model(pa[n_acc], pb[n_acc], 1'b0), acc, got);
      check("bp_hold_accept", 32'(acc), 0);
      check("bp_hold_result", 32'(result), 32'(sb[0].res));
      check("bp_hold_flags", 32'(dut_flags), 32'(sb[0].flg));
    end
    n_got = 0;
    for (int i = 0; i < 20 && n_got < 5; i++) begin
      if (n_acc < 5) step(1'b1, 1'b0, pa[n_acc], pb[n_acc], 1'b1, model(pa[n_acc], pb[n_acc], 1'b0), acc, got);
      else           idle(1'b1, acc, got);
      if (acc) n_acc++;
      if (got) n_got++;
    end
    check("bp_all_accepted", 32'(n_acc), 5);
    check("bp_delivered", 32'(n_got), 5);
    drain();

    // Randomized stream with random stalls
    for (int i = 0; i < 400; i++) begin
      xa = rand_op();
      xo = 1'($urandom);
      if ($urandom_range(0, 3) == 0) xb = {xa[15] ^ xo ^ 1'b1, xa[14:0] ^ 15'($urandom_range(0, 3))};
      else                           xb = rand_op();
      step(1'($urandom_range(0, 3) != 0), xo, xa, xb, 1'($urandom_range(0, 9) < 7),
           model(xa, xb, xo), acc, got);
    end
    drain();

    // Reset with operations in flight
    for (int i = 0; i < 3; i++) begin
      xa = rand_normal(); xb = rand_normal();
      step(1'b1, 1'b0, xa, xb, 1'b1, model(xa, xb, 1'b0), acc, got);
    end
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_out_valid", 32'(out_valid), 0);
    check("midrst_result", 32'(result), 0);
    check("midrst_flags", 32'(dut_flags), 0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 16'h3C00, 16'h4000, 1'b1, '{16'h4200, 4'b0000}, acc, got);
    check("midrst_accept", 32'(acc), 1);
    acc_step = step_no;
    seen = -1;
    for (int i = 0; i < 10 && seen < 0; i++) begin
      idle(1'b1, acc, got);
      if (got) seen = step_no;
    end
    check("midrst_latency", 32'(seen - acc_step), 3);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
